// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: 2-flop synchroniser, lock-out FSM and counter per channel.
// Optional hold-to-repeat press strobes are built when DEBOUNCE_MULTI_AUTO_REPEAT_EN is defined.
module debounce_multi #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 15_000_000,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] btn_input,
    output logic [NUM_CH-1:0] btn_output,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ZERO        = 2'd0,
        ZERO_TO_ONE = 2'd1,
        ONE         = 2'd2,
        ONE_TO_ZERO = 2'd3
    } state_t;

`ifdef DEBOUNCE_MULTI_AUTO_REPEAT_EN
    localparam int HW = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_START = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] REP_LAST   = HW'(HOLD_CYCLES + REPEAT_CYCLES - 1);
`else
    logic unused_cfg;
    assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic          sync1_q, sync2_q, s;
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          press_q, press_d, release_q, release_d;
        logic          repeat_fire;

        // Sync flops reset to the raw inactive level so s reads 0 during reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= ACTIVE_LOW;
                sync2_q <= ACTIVE_LOW;
            end else begin
                sync1_q <= btn_input[g];
                sync2_q <= sync1_q;
            end
        end

        assign s = sync2_q ^ ACTIVE_LOW;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            unique case (state_q)
                ZERO: if (s) begin
                    state_d = ZERO_TO_ONE;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
                ZERO_TO_ONE: if (cnt_q == CNT_LAST) begin
                    state_d = ONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                ONE: if (!s) begin
                    state_d   = ONE_TO_ZERO;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end
                ONE_TO_ZERO: if (cnt_q == CNT_LAST) begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                default: state_d = ZERO;
            endcase
        end

`ifdef DEBOUNCE_MULTI_AUTO_REPEAT_EN
        logic [HW-1:0] hold_q, hold_d;

        // hold_q counts cycles spent in ONE; after the first repeat it cycles
        // through HOLD..HOLD+REPEAT-1 so each wrap schedules the next strobe.
        always_comb begin
            hold_d      = '0;
            repeat_fire = 1'b0;
            if (state_q == ONE && s) begin
                repeat_fire = (hold_q == HOLD_LAST) || (hold_q == REP_LAST);
                hold_d      = (hold_q == REP_LAST) ? HOLD_START : hold_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) hold_q <= '0;
            else        hold_q <= hold_d;
        end
`else
        assign repeat_fire = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= ZERO;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d | repeat_fire;
                release_q <= release_d;
            end
        end

        assign btn_output[g]  = (state_q == ZERO_TO_ONE) || (state_q == ONE);
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
    end
endmodule

// File: tb/tb_debounce_multi.sv
// Directed and randomised bench for debounce_multi: one active-high and one active-low
// instance, both compared every cycle against a lock-out timing model.
module tb_debounce_multi;
    localparam int D    = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw_a, raw_b;
    logic [1:0] out_a, press_a, rel_a;
    logic [1:0] out_b, press_b, rel_b;

    debounce_multi #(.NUM_CH(2), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0),
                     .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_input(raw_a),
        .btn_output(out_a), .btn_press(press_a), .btn_release(rel_a));

    debounce_multi #(.NUM_CH(2), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1),
                     .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_input(raw_b),
        .btn_output(out_b), .btn_press(press_b), .btn_release(rel_b));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int np0, nr0, nh0;

    // Reference model: accepted level, edges still to ignore, age in the settled-high state.
    int m_lvl  [2][2];
    int m_wait [2][2];
    int m_age  [2][2];
    bit m_d1   [2][2];
    bit m_d2   [2][2];
    bit m_p    [2][2];
    bit m_r    [2][2];

    task automatic model_reset();
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 2; c++) begin
                m_lvl[u][c] = 0; m_wait[u][c] = 0; m_age[u][c] = 0;
                m_d1[u][c] = 1'b0; m_d2[u][c] = 1'b0;
                m_p[u][c] = 1'b0; m_r[u][c] = 1'b0;
            end
    endtask

    task automatic model_edge(input int u, input int c, input bit raw_s);
        bit s;
        s = m_d2[u][c];
        m_d2[u][c] = m_d1[u][c];
        m_d1[u][c] = raw_s;
        m_p[u][c] = 1'b0;
        m_r[u][c] = 1'b0;
        if (m_wait[u][c] > 0) begin
            m_wait[u][c]--;
            if (m_wait[u][c] == 0) m_age[u][c] = 0;
        end else if (int'(s) != m_lvl[u][c]) begin
            m_lvl[u][c]  = int'(s);
            m_wait[u][c] = D;
            if (s) m_p[u][c] = 1'b1;
            else   m_r[u][c] = 1'b1;
        end else if (m_lvl[u][c] == 1) begin
            m_age[u][c]++;
`ifdef DEBOUNCE_MULTI_AUTO_REPEAT_EN
            if (m_age[u][c] >= HOLD && (m_age[u][c] - HOLD) % REP == 0) m_p[u][c] = 1'b1;
`endif
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] eo[2], ep[2], er[2];
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 2; c++) begin
                eo[u][c] = (m_lvl[u][c] == 1);
                ep[u][c] = m_p[u][c];
                er[u][c] = m_r[u][c];
            end
        check({tag, "_out_a"}, out_a, eo[0]);
        check({tag, "_press_a"}, press_a, ep[0]);
        check({tag, "_rel_a"}, rel_a, er[0]);
        check({tag, "_out_b"}, out_b, eo[1]);
        check({tag, "_press_b"}, press_b, ep[1]);
        check({tag, "_rel_b"}, rel_b, er[1]);
        check({tag, "_excl_a"}, press_a & rel_a, 2'b00);
        check({tag, "_excl_b"}, press_b & rel_b, 2'b00);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
                model_edge(0, c, raw_a[c]);
                model_edge(1, c, ~raw_b[c]);
            end
        end
        #1;
        check_all(tag);
        if (press_a[0]) np0++;
        if (rel_a[0])   nr0++;
        if (out_a[0])   nh0++;
    endtask

    task automatic clear_counts();
        np0 = 0; nr0 = 0; nh0 = 0;
    endtask

    int exp_hold_presses;

    initial begin
        raw_a = 2'b00;
        raw_b = 2'b11;
        model_reset();
        clear_counts();

        // Reset held while ch0 is high: all outputs stay 0.
        raw_a = 2'b01;
        repeat (3) tick("rst_hold");
        check("rst_out_a", out_a, 2'b00);
        rst_n = 1'b1;
        tick("post_rst");
        tick("post_rst");
        tick("post_rst");
        check("t1_press_edge3", press_a, 2'b01);
        check("t1_out_edge3", out_a, 2'b01);
        repeat (8) tick("t1_hold");
        raw_a = 2'b00;
        repeat (12) tick("t1_drop");

        // Bounce after the rising edge: one press, no release.
        clear_counts();
        raw_a = 2'b01; tick("t2");
        raw_a = 2'b00; tick("t2");
        raw_a = 2'b01; tick("t2");
        raw_a = 2'b00; tick("t2");
        raw_a = 2'b01;
        repeat (12) tick("t2");
        check_int("t2_presses", np0, 1);
        check_int("t2_releases", nr0, 0);
        raw_a = 2'b00;
        repeat (12) tick("t2_drop");

        // Short glitch: high for lock-out plus one cycle, then release.
        clear_counts();
        raw_a = 2'b01; tick("t3"); tick("t3");
        raw_a = 2'b00;
        repeat (18) tick("t3");
        check_int("t3_presses", np0, 1);
        check_int("t3_releases", nr0, 1);
        check_int("t3_high_cycles", nh0, D + 1);

        // Active-low instance, then simultaneous edges across channels and instances.
        raw_b = 2'b01;
        repeat (3) tick("t4");
        check("t4_press_b_ch1", press_b, 2'b10);
        repeat (9) tick("t4");
        raw_b = 2'b11;
        repeat (12) tick("t4_rel");
        raw_b = 2'b00;
        raw_a = 2'b11;
        repeat (3) tick("t4_sim");
        check("t4_sim_press_b", press_b, 2'b11);
        check("t4_sim_press_a", press_a, 2'b11);
        repeat (9) tick("t4_sim");
        raw_a = 2'b00;
        raw_b = 2'b11;
        repeat (12) tick("t4_sim_rel");

        // Reset asserted during the rising lock-out aborts it without a release.
        raw_a = 2'b01;
        repeat (5) tick("t5");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_async_out_a", out_a, 2'b00);
        check_all("t5_async");
        clear_counts();
        repeat (3) tick("t5_in_rst");
        rst_n = 1'b1;
        repeat (12) tick("t5_after");
        check_int("t5_presses", np0, 1);
        check_int("t5_releases", nr0, 0);
        raw_a = 2'b00;
        repeat (12) tick("t5_drop");

        // Long hold: repeat strobes only when the repeat feature is built.
`ifdef DEBOUNCE_MULTI_AUTO_REPEAT_EN
        exp_hold_presses = 5;
`else
        exp_hold_presses = 1;
`endif
        clear_counts();
        raw_a = 2'b01;
        repeat (24) tick("t6_hold");
        raw_a = 2'b00;
        repeat (16) tick("t6_rel");
        check_int("t6_presses", np0, exp_hold_presses);
        check_int("t6_releases", nr0, 1);

        // Random phase with sparse level changes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) raw_a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) raw_b = 2'($urandom_range(0, 3));
            if (i % 40 == 0) begin
                if ($urandom_range(0, 1) == 0) raw_a = 2'b11;
            end
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
